// File: rtl/i8088_bus_pkg.sv
// -----------------------------------------------------------------------------
// i8088_bus_pkg
// Shared types and constants for the minimum-mode 8088 bus master.
//   bus_state_t   : T-state encoding of the bus-cycle FSM
//   STROBE_ON/OFF : levels of the active-low RD/WR/DEN strobes
//   IOM_IO/MEM    : levels of the IO/M pin
//   TIMEOUT_DATA  : read data returned when a cycle times out
// -----------------------------------------------------------------------------
package i8088_bus_pkg;

    typedef enum logic [2:0] {
        TI,
        T1,
        T2,
        T3,
        TW,
        T4,
        THOLD
    } bus_state_t;

    localparam logic       STROBE_ON    = 1'b0;
    localparam logic       STROBE_OFF   = 1'b1;
    localparam logic       IOM_IO       = 1'b1;
    localparam logic       IOM_MEM      = 1'b0;
    localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

    // States in which the data strobes and DEN are asserted.
    function automatic logic is_data_phase(input bus_state_t s);
        return (s == T2) || (s == T3) || (s == TW);
    endfunction

endpackage

// File: rtl/i8088_bus_master.sv
// -----------------------------------------------------------------------------
// i8088_bus_master
// Minimum-mode 8088 bus-cycle initiator. Turns a valid/ready request into a
// T1..T4 bus cycle (with READY wait states) and arbitrates HOLD/HLDA.
//
// Ports
//   CLK, RESET_N           : clock (rising edge), async active-low reset
//   req_valid/req_ready    : request handshake
//   req_write, req_io      : direction and address space of the request
//   req_addr, req_wdata    : 20-bit byte address, write data
//   resp_valid             : one-cycle completion pulse (in T4)
//   resp_rdata, resp_err   : read data / timeout flag, valid with resp_valid
//   READY                  : responder ready, sampled at the end of T3/TW
//   HOLD, HLDA             : external bus request / acknowledge
//   AD                     : multiplexed address[7:0] / data bus
//   A                      : address[19:8]
//   ALE, RD, WR, IOM, DTR, DEN : 8088 minimum-mode bus control
// -----------------------------------------------------------------------------
module i8088_bus_master
    import i8088_bus_pkg::*;
#(
    parameter int MAX_WAIT = 16,   // Tw states before abort; 0 = never abort
    parameter int WAIT_W   = 8     // MAX_WAIT must be < 2**WAIT_W
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_io,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic        resp_err,
    input  logic        READY,
    input  logic        HOLD,
    output logic        HLDA,
    inout  wire  [7:0]  AD,
    output logic [11:0] A,
    output logic        ALE,
    output logic        RD,
    output logic        WR,
    output logic        IOM,
    output logic        DTR,
    output logic        DEN
);

    bus_state_t        r_state;
    bus_state_t        w_next;
    logic              w_accept;
    logic              w_timeout;
    logic              w_sample;
    logic              w_data_next;

    logic [11:0]       r_addr_hi;
    logic [7:0]        r_wdata;
    logic              r_write;
    logic              r_io;
    logic              r_dtr;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [7:0]        r_rdata;
    logic              r_err;
    logic              r_ale;
    logic              r_rd;
    logic              r_wr;
    logic              r_den;
    logic              r_hlda;
    logic              r_resp_valid;
    logic              r_ready_base;
    logic              r_ad_oe;
    logic [7:0]        r_ad_out;

    // req_ready is decoded from the registered state, but gated by the live
    // HOLD so a handshake can never race a transition into THOLD.
    assign req_ready = r_ready_base & ~HOLD;
    assign w_accept  = req_valid & req_ready;
    assign w_sample  = (r_state == T3) || (r_state == TW);
    assign w_timeout = (MAX_WAIT != 0) && (r_wait_cnt == WAIT_W'(MAX_WAIT));

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            TI:      if (HOLD)          w_next = THOLD;
                     else if (w_accept) w_next = T1;
            T1:      w_next = T2;
            T2:      w_next = T3;
            T3:      w_next = READY ? T4 : TW;
            TW:      if (READY || w_timeout) w_next = T4;
            T4:      if (HOLD)          w_next = THOLD;
                     else if (w_accept) w_next = T1;
                     else               w_next = TI;
            THOLD:   if (!HOLD)         w_next = TI;
            default: w_next = TI;
        endcase
    end

    assign w_data_next = is_data_phase(w_next);

    // Bus pins are registered from the next state so they change exactly on
    // the clock edge that enters each T-state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= TI;
            r_addr_hi    <= '0;
            r_wdata      <= '0;
            r_write      <= 1'b0;
            r_io         <= 1'b0;
            r_dtr        <= 1'b1;
            r_wait_cnt   <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_ale        <= 1'b0;
            r_rd         <= STROBE_OFF;
            r_wr         <= STROBE_OFF;
            r_den        <= STROBE_OFF;
            r_hlda       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_ready_base <= 1'b0;
            r_ad_oe      <= 1'b0;
            r_ad_out     <= '0;
        end else begin
            r_state      <= w_next;
            r_ale        <= (w_next == T1);
            r_den        <= w_data_next ? STROBE_ON : STROBE_OFF;
            r_rd         <= (w_data_next && !r_write) ? STROBE_ON : STROBE_OFF;
            r_wr         <= (w_data_next &&  r_write) ? STROBE_ON : STROBE_OFF;
            r_hlda       <= (w_next == THOLD);
            r_resp_valid <= (w_next == T4);
            r_ready_base <= (w_next == TI) || (w_next == T4);
            r_ad_oe      <= (w_next == T1) || (w_data_next && r_write);

            if (w_accept) begin
                // DTR only moves here, while DEN is inactive.
                r_addr_hi  <= req_addr[19:8];
                r_wdata    <= req_wdata;
                r_write    <= req_write;
                r_io       <= req_io;
                r_dtr      <= req_write;
                r_err      <= 1'b0;
                r_wait_cnt <= '0;
                r_ad_out   <= req_addr[7:0];
            end else if (r_state == T1) begin
                // Switch AD from address to write data for T2; on reads the
                // driver is disabled so the value is never seen.
                r_ad_out <= r_wdata;
            end

            if (w_sample && READY) begin
                if (!r_write) r_rdata <= AD;
            end else if (r_state == T3) begin
                r_wait_cnt <= WAIT_W'(1);
            end else if (r_state == TW) begin
                if (w_timeout) begin
                    r_err <= 1'b1;
                    if (!r_write) r_rdata <= TIMEOUT_DATA;
                end else begin
                    r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                end
            end
        end
    end

    assign AD         = r_ad_oe ? r_ad_out : 8'hzz;
    assign A          = r_addr_hi;
    assign ALE        = r_ale;
    assign RD         = r_rd;
    assign WR         = r_wr;
    assign DEN        = r_den;
    assign DTR        = r_dtr;
    assign IOM        = r_io ? IOM_IO : IOM_MEM;
    assign HLDA       = r_hlda;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_i8088_bus_master.sv
// -----------------------------------------------------------------------------
// tb_i8088_bus_master
// Directed bench for i8088_bus_master. A read responder drives AD whenever RD
// is low; run_txn issues one request, steers READY and records what the bus
// did so each scenario task can compare against hand-computed values.
// -----------------------------------------------------------------------------
module tb_i8088_bus_master;

    logic        CLK;
    logic        RESET_N;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_io;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        resp_err;
    logic        READY;
    logic        HOLD;
    logic        HLDA;
    wire  [7:0]  AD;
    logic [11:0] A;
    logic        ALE;
    logic        RD;
    logic        WR;
    logic        IOM;
    logic        DTR;
    logic        DEN;

    logic [7:0]  tb_rsp;
    int          n_cmp;
    int          n_bad;

    // Observations filled by run_txn.
    int          o_clocks;
    int          o_rd_low;
    int          o_wr_low;
    logic [25:0] o_t1;     // {ALE, AD, A, IOM, DTR, DEN, RD, WR} in T1
    logic [12:0] o_t2;     // {ALE, AD, DEN, DTR, RD, WR} in T2
    logic [2:0]  o_t4;     // {RD, WR, DEN} in T4
    logic [7:0]  o_rdata;
    logic        o_err;

    assign AD = (RD == 1'b0) ? tb_rsp : 8'hzz;

    i8088_bus_master #(
        .MAX_WAIT (16),
        .WAIT_W   (8)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_io     (req_io),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .READY      (READY),
        .HOLD       (HOLD),
        .HLDA       (HLDA),
        .AD         (AD),
        .A          (A),
        .ALE        (ALE),
        .RD         (RD),
        .WR         (WR),
        .IOM        (IOM),
        .DTR        (DTR),
        .DEN        (DEN)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    // Called at a negedge with the DUT able to accept. nwait < 0 keeps READY
    // low forever; otherwise READY is low for nwait samples in T3/TW. READY is
    // held high in T1/T2 where it must be ignored. Returns at the T4 negedge.
    task automatic run_txn(input logic wr, input logic io, input logic [19:0] addr,
                           input logic [7:0] wdata, input logic [7:0] rsp, input int nwait);
        int k;
        req_valid = 1'b1;
        req_write = wr;
        req_io    = io;
        req_addr  = addr;
        req_wdata = wdata;
        tb_rsp    = rsp;
        READY     = 1'b1;
        @(negedge CLK);
        req_valid = 1'b0;
        o_clocks  = 1;
        o_rd_low  = 0;
        o_wr_low  = 0;
        k         = 0;
        o_t1      = {ALE, AD, A, IOM, DTR, DEN, RD, WR};
        o_t2      = '0;
        while (resp_valid !== 1'b1 && o_clocks < 60) begin
            if (o_clocks >= 3) begin
                READY = (nwait >= 0) && (k >= nwait);
                k++;
            end
            @(negedge CLK);
            o_clocks++;
            if (o_clocks == 2) o_t2 = {ALE, AD, DEN, DTR, RD, WR};
            if (resp_valid !== 1'b1) begin
                if (RD === 1'b0) o_rd_low++;
                if (WR === 1'b0) o_wr_low++;
            end
        end
        o_t4    = {RD, WR, DEN};
        o_rdata = resp_rdata;
        o_err   = resp_err;
        READY   = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        n_cmp++;
        if ({ALE, RD, WR, DEN, DTR, IOM} !== 6'b011110) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b expected %b", {ALE, RD, WR, DEN, DTR, IOM}, 6'b011110);
        end
        n_cmp++;
        if (A !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_addr: got %h expected %h", A, 12'h000);
        end
        n_cmp++;
        if ({HLDA, req_ready, resp_valid, resp_err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected %b", {HLDA, req_ready, resp_valid, resp_err}, 4'b0000);
        end
        n_cmp++;
        if (resp_rdata !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h expected %h", resp_rdata, 8'h00);
        end
        RESET_N = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b expected %b", req_ready, 1'b1);
        end
    endtask

    task automatic test_mem_write();
        run_txn(1'b1, 1'b0, 20'h00123, 8'hA5, 8'h00, 0);
        n_cmp++;
        if (o_t1 !== {1'b1, 8'h23, 12'h001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL write_t1: got %h expected %h", o_t1, {1'b1, 8'h23, 12'h001, 5'b01111});
        end
        n_cmp++;
        if (o_t2 !== {1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL write_t2: got %h expected %h", o_t2, {1'b0, 8'hA5, 4'b0110});
        end
        n_cmp++;
        if ({o_clocks, o_wr_low, o_rd_low} !== {32'd4, 32'd2, 32'd0}) begin
            n_bad++;
            $display("FAIL write_timing: got clocks=%0d wr_low=%0d rd_low=%0d expected 4 2 0", o_clocks, o_wr_low, o_rd_low);
        end
        n_cmp++;
        if ({o_t4, o_err, o_rdata} !== {3'b111, 1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL write_t4: got t4=%b err=%b rdata=%h expected 111 0 00", o_t4, o_err, o_rdata);
        end
        @(negedge CLK);
        n_cmp++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL write_pulse: got %b expected %b", {resp_valid, req_ready}, 2'b01);
        end
    endtask

    task automatic test_io_read();
        run_txn(1'b0, 1'b1, 20'h0003C, 8'h00, 8'h5A, 0);
        n_cmp++;
        if (o_t1 !== {1'b1, 8'h3C, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL ioread_t1: got %h expected %h", o_t1, {1'b1, 8'h3C, 12'h000, 5'b10111});
        end
        n_cmp++;
        if (o_t2 !== {1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL ioread_t2: got %h expected %h", o_t2, {1'b0, 8'h5A, 4'b0001});
        end
        n_cmp++;
        if ({o_clocks, o_rd_low, o_wr_low} !== {32'd4, 32'd2, 32'd0}) begin
            n_bad++;
            $display("FAIL ioread_timing: got clocks=%0d rd_low=%0d wr_low=%0d expected 4 2 0", o_clocks, o_rd_low, o_wr_low);
        end
        n_cmp++;
        if ({o_rdata, o_err} !== {8'h5A, 1'b0}) begin
            n_bad++;
            $display("FAIL ioread_data: got rdata=%h err=%b expected 5a 0", o_rdata, o_err);
        end
        @(negedge CLK);
    endtask

    task automatic test_wait_states();
        run_txn(1'b0, 1'b0, 20'hABCDE, 8'h00, 8'hC3, 3);
        n_cmp++;
        if (o_t1 !== {1'b1, 8'hDE, 12'hABC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL wait_t1: got %h expected %h", o_t1, {1'b1, 8'hDE, 12'hABC, 5'b00111});
        end
        n_cmp++;
        if ({o_clocks, o_rd_low} !== {32'd7, 32'd5}) begin
            n_bad++;
            $display("FAIL wait_timing: got clocks=%0d rd_low=%0d expected 7 5", o_clocks, o_rd_low);
        end
        n_cmp++;
        if ({o_rdata, o_err, o_t4} !== {8'hC3, 1'b0, 3'b111}) begin
            n_bad++;
            $display("FAIL wait_data: got rdata=%h err=%b t4=%b expected c3 0 111", o_rdata, o_err, o_t4);
        end
        @(negedge CLK);
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 1'b0, 20'h0F0F0, 8'h00, 8'h77, -1);
        n_cmp++;
        if ({o_clocks, o_rd_low} !== {32'd20, 32'd18}) begin
            n_bad++;
            $display("FAIL timeout_timing: got clocks=%0d rd_low=%0d expected 20 18", o_clocks, o_rd_low);
        end
        n_cmp++;
        if ({o_rdata, o_err} !== {8'hFF, 1'b1}) begin
            n_bad++;
            $display("FAIL timeout_resp: got rdata=%h err=%b expected ff 1", o_rdata, o_err);
        end
        n_cmp++;
        if (o_t4 !== 3'b111) begin
            n_bad++;
            $display("FAIL timeout_release: got %b expected %b", o_t4, 3'b111);
        end
        @(negedge CLK);
        // A following write with one wait state clears the error and leaves
        // the read data untouched.
        run_txn(1'b1, 1'b0, 20'h00200, 8'h3C, 8'h00, 1);
        n_cmp++;
        if ({o_clocks, o_err, o_rdata} !== {32'd5, 1'b0, 8'hFF}) begin
            n_bad++;
            $display("FAIL timeout_recover: got clocks=%0d err=%b rdata=%h expected 5 0 ff", o_clocks, o_err, o_rdata);
        end
        @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        int hold_bad;
        hold_bad  = 0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_io    = 1'b0;
        req_addr  = 20'h45678;
        req_wdata = 8'h11;
        READY     = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if ({ALE, AD, A} !== {1'b1, 8'h78, 12'h456}) begin
            n_bad++;
            $display("FAIL b2b_first_t1: got %h expected %h", {ALE, AD, A}, {1'b1, 8'h78, 12'h456});
        end
        req_addr  = 20'h9ABCD;
        req_wdata = 8'h22;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if ({resp_valid, req_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL b2b_first_t4: got %b expected %b", {resp_valid, req_ready}, 2'b11);
        end
        @(negedge CLK);
        n_cmp++;
        if ({ALE, AD, A, resp_valid} !== {1'b1, 8'hCD, 12'h9AB, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_second_t1: got %h expected %h", {ALE, AD, A, resp_valid}, {1'b1, 8'hCD, 12'h9AB, 1'b0});
        end
        req_valid = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ({WR, AD} !== {1'b0, 8'h22}) begin
            n_bad++;
            $display("FAIL b2b_second_t2: got %h expected %h", {WR, AD}, {1'b0, 8'h22});
        end
        HOLD = 1'b1;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({resp_valid, HLDA, req_ready, WR} !== 4'b1001) begin
            n_bad++;
            $display("FAIL b2b_hold_t4: got %b expected %b", {resp_valid, HLDA, req_ready, WR}, 4'b1001);
        end
        // A pending request must not be taken while the bus is held.
        req_valid = 1'b1;
        req_addr  = 20'h00777;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if ({HLDA, req_ready, ALE, RD, WR, DEN} !== 6'b100111) hold_bad++;
        end
        n_cmp++;
        if (hold_bad !== 0) begin
            n_bad++;
            $display("FAIL b2b_thold: got %0d bad cycles expected 0", hold_bad);
        end
        req_valid = 1'b0;
        HOLD      = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ({HLDA, req_ready, ALE} !== 3'b010) begin
            n_bad++;
            $display("FAIL b2b_unhold: got %b expected %b", {HLDA, req_ready, ALE}, 3'b010);
        end
    endtask

    task automatic test_reset_mid_cycle();
        int rv_seen;
        rv_seen   = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_io    = 1'b0;
        req_addr  = 20'h01234;
        tb_rsp    = 8'h99;
        READY     = 1'b0;
        @(negedge CLK);
        req_valid = 1'b0;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({RD, DEN} !== 2'b00) begin
            n_bad++;
            $display("FAIL midrst_in_t3: got %b expected %b", {RD, DEN}, 2'b00);
        end
        #2 RESET_N = 1'b0;
        #1;
        n_cmp++;
        if ({ALE, RD, WR, DEN, DTR, IOM} !== 6'b011110) begin
            n_bad++;
            $display("FAIL midrst_ctrl: got %b expected %b", {ALE, RD, WR, DEN, DTR, IOM}, 6'b011110);
        end
        n_cmp++;
        if ({A, resp_valid, resp_rdata, resp_err, HLDA, req_ready} !== 24'h0) begin
            n_bad++;
            $display("FAIL midrst_state: got %h expected %h", {A, resp_valid, resp_rdata, resp_err, HLDA, req_ready}, 24'h0);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        READY   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (resp_valid !== 1'b0) rv_seen++;
        end
        n_cmp++;
        if (rv_seen !== 0) begin
            n_bad++;
            $display("FAIL midrst_no_resp: got %0d pulses expected 0", rv_seen);
        end
        run_txn(1'b0, 1'b0, 20'hF00A0, 8'h00, 8'h3E, 0);
        n_cmp++;
        if ({o_clocks, o_rdata, o_err} !== {32'd4, 8'h3E, 1'b0}) begin
            n_bad++;
            $display("FAIL midrst_after: got clocks=%0d rdata=%h err=%b expected 4 3e 0", o_clocks, o_rdata, o_err);
        end
        @(negedge CLK);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        RESET_N   = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_io    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        READY     = 1'b1;
        HOLD      = 1'b0;
        tb_rsp    = 8'h00;
        #2 RESET_N = 1'b0;

        test_reset();
        test_mem_write();
        test_io_read();
        test_wait_states();
        test_timeout();
        test_back_to_back();
        test_reset_mid_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i8088_bus_master.md
Name: i8088_bus_master

Overview:
- Minimum-mode 8088 bus-cycle initiator; the master end of the bus that IO_MEM responds to.
- Converts a simple request/response interface into T1–T4 bus cycles: ALE, RD, WR, IOM, DTR, DEN and multiplexed AD/A.
- Honours READY wait states and HOLD/HLDA.
- Sits between test-sequence or core logic and the 8282 latch / 8286 transceiver / IO_MEM fabric.

Parameters:
- MAX_WAIT, 16: Tw states tolerated before the cycle is aborted; 0 disables the timeout.
- WAIT_W, 8: wait-counter width; MAX_WAIT must be < 2**WAIT_W.

Ports:
- CLK  input  1  bus clock; all state updates on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted this cycle when req_valid & req_ready.
- req_write  input  1  1 = write, 0 = read.
- req_io  input  1  1 = I/O space, 0 = memory.
- req_addr  input  20  byte address.
- req_wdata  input  8  write data.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  8  read data, valid with resp_valid.
- resp_err  output  1  timeout flag, valid with resp_valid.
- READY  input  1  responder ready, sampled in T3/Tw.
- HOLD  input  1  bus request from an external master.
- HLDA  output  1  hold acknowledge.
- AD  inout  8  multiplexed address[7:0] / data.
- A  output  12  address[19:8].
- ALE  output  1  address latch enable, active high.
- RD  output  1  read strobe, active low.
- WR  output  1  write strobe, active low.
- IOM  output  1  1 = I/O, 0 = memory.
- DTR  output  1  1 = transmit (write), 0 = receive.
- DEN  output  1  data enable, active low.

Behaviour:
- Reset state (async on RESET_N low, immediate):
  - state = TI; ALE = 0, RD = 1, WR = 1, DEN = 1, DTR = 1, IOM = 0, A = 0, AD released (z).
  - HLDA = 0, req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, wait counter = 0.
- States: TI, T1, T2, T3, TW, T4, THOLD. All outputs are registered from state plus latched request fields.
- Acceptance:
  - req_ready = 1 only in TI and T4, and only when HOLD = 0.
  - On handshake, latch addr/wdata/write/io and go to T1.
- T1:
  - ALE = 1; AD = addr[7:0]; A = addr[19:8]; IOM = io; DTR = write; DEN = 1; RD = WR = 1.
- T2:
  - ALE = 0; A held; DEN = 0.
  - Write: AD = wdata, WR = 0.
  - Read: AD released, RD = 0.
  - Always go to T3.
- T3:
  - Strobes and DEN held.
  - READY = 1: capture AD into resp_rdata (reads), go to T4.
  - READY = 0: go to TW, wait counter = 1.
- TW:
  - Same outputs as T3.
  - READY = 1: capture, go to T4.
  - Else if MAX_WAIT != 0 and counter == MAX_WAIT: go to T4 with err latched, resp_rdata = 8'hFF.
  - Else counter++.
- T4:
  - RD = WR = 1, DEN = 1; AD released; resp_valid = 1 for this cycle only; resp_err as latched.
  - Next state, in priority order: HOLD → THOLD; new handshake → T1 (back-to-back, no TI); otherwise TI.
- TI:
  - HOLD = 1 → THOLD, with priority over req_valid; else handshake → T1.
- THOLD:
  - HLDA = 1; AD released; RD/WR/DEN = 1; ALE = 0; req_ready = 0.
  - When HOLD = 0: HLDA = 0 the next cycle, go to TI.
- HOLD raised mid-cycle (T1–TW) is ignored until T4; the cycle always completes.
- READY is don't-care outside T3/TW.
- Write cycles: resp_rdata is unchanged.
- DTR changes only in T1 and never while DEN = 0.
- Reset asserted mid-cycle: the cycle is abandoned, no resp_valid, bus returns to reset values at once.
- Minimum cycle = 4 clocks (T1–T4); each Tw adds 1.
- Back-to-back throughput = one transaction per 4 clocks.

Decomposition:
- Package i8088_bus_pkg:
  - typedef enum bus_state_t {TI, T1, T2, T3, TW, T4, THOLD};
  - constants STROBE_ON = 1'b0, STROBE_OFF = 1'b1, IOM_IO = 1'b1, IOM_MEM = 1'b0, TIMEOUT_DATA = 8'hFF.
- No sub-module needed; a single FSM plus datapath registers.
- The AD tri-state driver is a continuous assign on a registered ad_oe/ad_out pair.

Test Plan:
- Memory write addr 20'h00123, data 8'hA5, READY = 1: ALE high in T1 with AD = 8'h23, A = 12'h001, IOM = 0; WR low in T2–T3 with AD = 8'hA5, DTR = 1; resp_valid in T4, resp_err = 0; 4 clocks.
- I/O read addr 20'h0003C, responder returns 8'h5A: IOM = 1, DTR = 0 from T1, RD low in T2–T3; resp_rdata = 8'h5A, resp_err = 0.
- Read with READY low for 3 samples: exactly 3 TW states, RD held low throughout, completion in 7 clocks, correct data.
- READY held low, MAX_WAIT = 16: 16 TW states, then T4 with resp_err = 1, resp_rdata = 8'hFF, strobes released.
- Two back-to-back writes with req_valid held: second ALE occurs the clock after the first T4, no TI between; HOLD raised during the second T2 → HLDA = 1 only after its T4, bus released, req_ready = 0 until HOLD drops.
- RESET_N pulsed low during T3 of a read: outputs return to reset values asynchronously, no resp_valid, next request after reset completes normally.
